// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants for the tone generator and I2S output stages
// Contents: SAMPLE_W (PCM width), FRAME_BITS (one stereo I2S frame), i2s_slot_e (LEFT/RIGHT word select).
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 2 * SAMPLE_W;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_slot_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - I2S bit clock divider with a one-cycle falling-edge strobe
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   enable in   1 = divide and toggle bclk; 0 = hold div_cnt and bclk at 0
//   bclk   out  I2S bit clock, BCLK_DIV clk cycles per half-period
//   fe     out  high in the cycle whose rising clk edge drives bclk from 1 to 0
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic fe
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tc;

    assign tc = (div_cnt == DIV_LAST);

    // Combinational so the serial state in the parent registers on the same
    // edge that takes bclk low.
    assign fe = enable && !reset && tc && bclk;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// rtl/i2s_sample_tx.sv - paces the sample generator and serialises mono PCM as Philips I2S
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   enable           in   1 = run the serialiser; 0 = idle with bclk/lrclk/sdata low
//   sample_in        in   signed PCM word from the generator
//   new_sample_ready in   one-cycle strobe, sample_in valid this cycle
//   generate_next    out  one-cycle request for the next sample (start of right slot)
//   bclk             out  I2S bit clock
//   lrclk            out  I2S word select, 0 = left
//   sdata            out  I2S serial data, MSB first, same word in both slots
//   underrun         out  sticky: a frame started without a fresh sample
module i2s_sample_tx #(
    parameter int BCLK_DIV = 4,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                new_sample_ready,
    output logic                generate_next,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun
);

    import audio_pkg::*;

    localparam int FRAME_LEN = 2 * SAMPLE_W;
    localparam int BW        = $clog2(FRAME_LEN);

    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_LEN - 1);
    localparam logic [BW-1:0] BIT_RIGHT = BW'(SAMPLE_W);
    localparam logic [BW-1:0] LR_FIRST  = BW'(SAMPLE_W - 1);
    localparam logic [BW-1:0] LR_LAST   = BW'(FRAME_LEN - 2);

    logic                fe;
    logic [BW-1:0]       bit_cnt;
    logic [BW-1:0]       bit_next;
    logic [SAMPLE_W-1:0] shift;
    logic [SAMPLE_W-1:0] frame_word;
    logic [SAMPLE_W-1:0] pending;
    logic                pend_valid;
    logic [SAMPLE_W-1:0] load_word;
    i2s_slot_e           slot_next;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bclk   (bclk),
        .fe     (fe)
    );

    // sdata is always the MSB of the shifter; clearing the shifter on reset or
    // disable is what drives the line low.
    assign sdata = shift[SAMPLE_W-1];

    always_comb begin
        bit_next  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        slot_next = LEFT;
        // Word select switches one BCLK ahead of the slot it names.
        if (bit_next >= LR_FIRST && bit_next <= LR_LAST) begin
            slot_next = RIGHT;
        end
        // Frame word priority: captured sample, then same-cycle bypass, then repeat.
        if (pend_valid) begin
            load_word = pending;
        end else if (new_sample_ready) begin
            load_word = sample_in;
        end else begin
            load_word = frame_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt       <= BIT_LAST;
            lrclk         <= 1'b0;
            generate_next <= 1'b0;
            underrun      <= 1'b0;
            pending       <= '0;
            pend_valid    <= 1'b0;
            shift         <= '0;
            frame_word    <= '0;
        end else begin
            generate_next <= 1'b0;

            // Capture runs regardless of enable; the newest strobe overwrites.
            if (new_sample_ready) begin
                pending    <= sample_in;
                pend_valid <= 1'b1;
            end

            if (!enable) begin
                bit_cnt <= BIT_LAST;
                lrclk   <= 1'b0;
                shift   <= '0;
            end else if (fe) begin
                bit_cnt <= bit_next;
                lrclk   <= slot_next;
                if (bit_next == '0) begin
                    shift      <= load_word;
                    frame_word <= load_word;
                    // Overrides the capture above: a same-cycle strobe is consumed by the bypass.
                    pend_valid <= 1'b0;
                    if (!pend_valid && !new_sample_ready) begin
                        underrun <= 1'b1;
                    end
                end else if (bit_next == BIT_RIGHT) begin
                    shift         <= frame_word;
                    generate_next <= 1'b1;
                end else begin
                    shift <= {shift[SAMPLE_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb/tb_i2s_sample_tx.sv - directed self-checking bench for i2s_sample_tx (BCLK_DIV=2, SAMPLE_W=16)
module tb_i2s_sample_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] sample_in;
    logic        new_sample_ready;
    logic        generate_next;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    i2s_sample_tx #(
        .BCLK_DIV (2),
        .SAMPLE_W (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .sample_in        (sample_in),
        .new_sample_ready (new_sample_ready),
        .generate_next    (generate_next),
        .bclk             (bclk),
        .lrclk            (lrclk),
        .sdata            (sdata),
        .underrun         (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset 3 cycles (counting non-zero outputs), releases it with a priming
    // strobe, and returns bclk after each of the next 4 edges. Ends at the first FE.
    task automatic start_from_reset(input logic [15:0] prime, output int rst_bad,
                                    output logic [3:0] bclk_seq);
        rst_bad          = 0;
        reset            = 1'b1;
        enable           = 1'b1;
        new_sample_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({bclk, lrclk, sdata, generate_next, underrun} !== 5'b0) rst_bad++;
        end
        reset            = 1'b0;
        new_sample_ready = 1'b1;
        sample_in        = prime;
        for (int i = 3; i >= 0; i--) begin
            tick();
            new_sample_ready = 1'b0;
            bclk_seq[i] = bclk;
        end
    endtask

    // Starts right after the bit_cnt=0 FE and ends right after the next one.
    // mode 0: ignore request; 1: answer d1 5 cycles after request;
    // 2: d1 at +5 and d2 at +10; 3: ignore request, strobe d1 on the closing load edge.
    task automatic run_frame(input int mode, input logic [15:0] d1, input logic [15:0] d2,
                             output logic [15:0] l, output logic [15:0] r,
                             output logic [31:0] lr, output int gn_n, output int gn_pos);
        int cd1;
        int cd2;
        cd1 = 0; cd2 = 0; gn_n = 0; gn_pos = -1; l = '0; r = '0; lr = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < 16) l[15-k] = sdata;
            else        r[31-k] = sdata;
            lr[k] = lrclk;
            for (int c = 0; c < 4; c++) begin
                if (generate_next === 1'b1) begin
                    gn_n++;
                    gn_pos = k * 4 + c;
                    if (mode == 1 || mode == 2) cd1 = 5;
                    if (mode == 2) cd2 = 10;
                end
                new_sample_ready = 1'b0;
                if (cd1 == 1) begin new_sample_ready = 1'b1; sample_in = d1; end
                if (cd2 == 1) begin new_sample_ready = 1'b1; sample_in = d2; end
                if (mode == 3 && k == 31 && c == 3) begin
                    new_sample_ready = 1'b1;
                    sample_in = d1;
                end
                tick();
                if (cd1 > 0) cd1--;
                if (cd2 > 0) cd2--;
            end
        end
        new_sample_ready = 1'b0;
    endtask

    task automatic test_reset();
        int          bad;
        logic [3:0]  seq;
        logic [15:0] l, r;
        logic [31:0] lr;
        int          gn_n, gn_pos;
        start_from_reset(16'hA5C3, bad, seq);
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_outputs: nonzero cycles=%0d expected 0", bad); end
        checks++; if (seq !== 4'b0110) begin errors++; $display("FAIL first_fe_bclk: got %b expected 0110", seq); end
        checks++; if (sdata !== 1'b1) begin errors++; $display("FAIL first_msb: got %b expected 1", sdata); end
        run_frame(1, 16'hA5C3, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'hA5C3) begin errors++; $display("FAIL reset_left: got %h expected a5c3", l); end
        checks++; if (r !== 16'hA5C3) begin errors++; $display("FAIL reset_right: got %h expected a5c3", r); end
        checks++; if (lr !== 32'h7FFF8000) begin errors++; $display("FAIL lrclk_pattern: got %h expected 7fff8000", lr); end
        checks++; if (gn_n !== 1) begin errors++; $display("FAIL gen_count: got %0d expected 1", gn_n); end
        checks++; if (gn_pos !== 64) begin errors++; $display("FAIL gen_position: got %0d expected 64", gn_pos); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_normal();
        logic [15:0] l, r;
        logic [31:0] lr;
        int          gn_n, gn_pos;
        run_frame(1, 16'h8001, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'hA5C3) begin errors++; $display("FAIL normal_left: got %h expected a5c3", l); end
        checks++; if (r !== 16'hA5C3) begin errors++; $display("FAIL normal_right: got %h expected a5c3", r); end
        run_frame(1, 16'hA5C3, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'h8001) begin errors++; $display("FAIL signbit_left: got %h expected 8001", l); end
        checks++; if (r !== 16'h8001) begin errors++; $display("FAIL signbit_right: got %h expected 8001", r); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL normal_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_two_strobes();
        logic [15:0] l, r;
        logic [31:0] lr;
        int          gn_n, gn_pos;
        run_frame(2, 16'h1111, 16'h7FFF, l, r, lr, gn_n, gn_pos);
        run_frame(1, 16'hC3A5, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'h7FFF) begin errors++; $display("FAIL latest_left: got %h expected 7fff", l); end
        checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL latest_right: got %h expected 7fff", r); end
    endtask

    task automatic test_bypass();
        logic [15:0] l, r;
        logic [31:0] lr;
        int          gn_n, gn_pos;
        run_frame(3, 16'h0F0F, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'hC3A5) begin errors++; $display("FAIL pre_bypass_left: got %h expected c3a5", l); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL bypass_underrun: got %b expected 0", underrun); end
        run_frame(1, 16'hA5C3, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'h0F0F) begin errors++; $display("FAIL bypass_left: got %h expected 0f0f", l); end
        checks++; if (r !== 16'h0F0F) begin errors++; $display("FAIL bypass_right: got %h expected 0f0f", r); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL bypass_underrun2: got %b expected 0", underrun); end
    endtask

    task automatic test_withhold();
        logic [15:0] l, r;
        logic [31:0] lr;
        int          gn_n, gn_pos;
        run_frame(0, 16'h0, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
        run_frame(1, 16'h1234, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'hA5C3) begin errors++; $display("FAIL repeat_left: got %h expected a5c3", l); end
        checks++; if (r !== 16'hA5C3) begin errors++; $display("FAIL repeat_right: got %h expected a5c3", r); end
        run_frame(1, 16'hA5C3, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'h1234) begin errors++; $display("FAIL after_underrun_left: got %h expected 1234", l); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
    endtask

    task automatic test_reset_mid();
        int          bad;
        logic [3:0]  seq;
        logic [15:0] l, r;
        logic [31:0] lr;
        int          gn_n, gn_pos;
        for (int i = 0; i < 28; i++) tick();
        // bit_cnt=7 of the left slot carries bit 8 of a5c3
        checks++; if ({lrclk, sdata} !== 2'b01) begin errors++; $display("FAIL mid_bit7: got %b expected 01", {lrclk, sdata}); end
        start_from_reset(16'hA5C3, bad, seq);
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_reset_outputs: nonzero cycles=%0d expected 0", bad); end
        checks++; if (seq !== 4'b0110) begin errors++; $display("FAIL mid_first_fe: got %b expected 0110", seq); end
        run_frame(1, 16'hA5C3, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'hA5C3 || r !== 16'hA5C3) begin errors++; $display("FAIL mid_restart_frame: got %h/%h expected a5c3/a5c3", l, r); end
        checks++; if (gn_pos !== 64) begin errors++; $display("FAIL mid_gen_position: got %0d expected 64", gn_pos); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_enable();
        int          bad;
        logic [3:0]  seq;
        logic [15:0] l, r;
        logic [31:0] lr;
        int          gn_n, gn_pos;
        bad    = 0;
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            new_sample_ready = (i == 20);
            sample_in        = 16'h3C5A;
            tick();
            if ({bclk, lrclk, sdata, generate_next} !== 4'b0) bad++;
        end
        new_sample_ready = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL disabled_idle: active cycles=%0d expected 0", bad); end
        enable = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tick();
            seq[i] = bclk;
        end
        checks++; if (seq !== 4'b0110) begin errors++; $display("FAIL reenable_fe: got %b expected 0110", seq); end
        run_frame(1, 16'hA5C3, 16'h0, l, r, lr, gn_n, gn_pos);
        checks++; if (l !== 16'h3C5A || r !== 16'h3C5A) begin errors++; $display("FAIL reenable_frame: got %h/%h expected 3c5a/3c5a", l, r); end
        checks++; if (lr !== 32'h7FFF8000) begin errors++; $display("FAIL reenable_lrclk: got %h expected 7fff8000", lr); end
        checks++; if (gn_n !== 1 || gn_pos !== 64) begin errors++; $display("FAIL reenable_gen: got %0d@%0d expected 1@64", gn_n, gn_pos); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reenable_underrun: got %b expected 0", underrun); end
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        sample_in        = 16'h0;
        new_sample_ready = 1'b0;
        test_reset();
        test_normal();
        test_two_strobes();
        test_bypass();
        test_withhold();
        test_reset_mid();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
